// File: rtl/mem_stream_responder.sv
// Stream responder over an internal dual-port word memory: independent read-stream and write-stream FSMs.
// Optional LFSR stall insertion when MEM_RESP_BACKPRESSURE_EN is defined.
module mem_stream_responder #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH_WORDS    = 1024
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_raddr_offset_i,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_rxfer_size_i,
  input  logic                          ctrl_rstart_i,
  output logic                          ctrl_rdone_o,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rd_tdata_o,
  output logic                          rd_tvalid_o,
  input  logic                          rd_tready_i,
  output logic                          rd_tlast_o,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_waddr_offset_i,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_wxfer_size_i,
  input  logic                          ctrl_wstart_i,
  output logic                          ctrl_wdone_o,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] wr_tdata_i,
  input  logic                          wr_tvalid_i,
  output logic                          wr_tready_o
);

  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam int unsigned XW = C_XFER_SIZE_WIDTH;
  localparam int unsigned IW = $clog2(MEM_DEPTH_WORDS);

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM, R_DONE} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_DONE} wstate_t;

  // ceil(size/4) without overflowing on sizes near the top of the range
  function automatic logic [XW-1:0] beats_of(input logic [XW-1:0] size);
    return (size >> 2) + XW'(|size[1:0]);
  endfunction

  logic [DW-1:0] mem [MEM_DEPTH_WORDS];

  logic          unused_c;
  logic          gate_c;
  logic [XW-1:0] r_beats_c;
  logic [XW-1:0] w_beats_c;
  logic          r_hs_c;
  logic          w_hs_c;

  rstate_t       r_state;
  rstate_t       r_state_nxt;
  logic [IW-1:0] r_idx;
  logic [XW-1:0] r_left;
  logic          r_primed;
  logic [DW-1:0] r_pf;

  wstate_t       w_state;
  wstate_t       w_state_nxt;
  logic [IW-1:0] w_idx;
  logic [XW-1:0] w_left;

  assign unused_c  = ^{ctrl_raddr_offset_i, ctrl_waddr_offset_i};
  assign r_beats_c = beats_of(ctrl_rxfer_size_i);
  assign w_beats_c = beats_of(ctrl_wxfer_size_i);
  assign r_hs_c    = rd_tvalid_o & rd_tready_i;
  assign w_hs_c    = wr_tvalid_i & wr_tready_o;

`ifdef MEM_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_nxt_c;

  assign lfsr_nxt_c = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign gate_c     = lfsr_nxt_c[0];

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) lfsr_q <= 16'hACE1;
    else      lfsr_q <= lfsr_nxt_c;
  end
`else
  assign gate_c = 1'b1;
`endif

  // read FSM state register
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) r_state <= R_IDLE;
    else      r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:   if (ctrl_rstart_i) r_state_nxt = (r_beats_c == '0) ? R_DONE : R_FETCH;
      R_FETCH:  if (r_primed) r_state_nxt = R_STREAM;
      R_STREAM: if (r_hs_c && (r_left == XW'(1))) r_state_nxt = R_DONE;
      R_DONE:   r_state_nxt = R_IDLE;
      default:  r_state_nxt = R_IDLE;
    endcase
  end

  // read datapath: r_pf always holds the word after the one on rd_tdata_o
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_idx        <= '0;
      r_left       <= '0;
      r_primed     <= 1'b0;
      r_pf         <= '0;
      rd_tdata_o   <= '0;
      rd_tvalid_o  <= 1'b0;
      rd_tlast_o   <= 1'b0;
      ctrl_rdone_o <= 1'b0;
    end else begin
      rd_tvalid_o  <= (r_state_nxt == R_STREAM) & gate_c;
      ctrl_rdone_o <= (r_state_nxt == R_DONE);
      case (r_state)
        R_IDLE: begin
          r_primed <= 1'b0;
          if (ctrl_rstart_i) begin
            r_idx  <= ctrl_raddr_offset_i[IW+1:2];
            r_left <= r_beats_c;
          end
        end
        R_FETCH: begin
          r_pf     <= mem[r_idx];
          r_idx    <= r_idx + IW'(1);
          r_primed <= 1'b1;
          if (r_primed) begin
            rd_tdata_o <= r_pf;
            rd_tlast_o <= (r_left == XW'(1));
          end
        end
        R_STREAM: begin
          if (r_hs_c) begin
            r_left <= r_left - XW'(1);
            if (r_left == XW'(1)) begin
              rd_tlast_o <= 1'b0;
            end else begin
              rd_tdata_o <= r_pf;
              rd_tlast_o <= (r_left == XW'(2));
              r_pf       <= mem[r_idx];
              r_idx      <= r_idx + IW'(1);
            end
          end
        end
        default: begin
          r_primed <= 1'b0;
        end
      endcase
    end
  end

  // write FSM state register
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) w_state <= W_IDLE;
    else      w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:   if (ctrl_wstart_i) w_state_nxt = (w_beats_c == '0) ? W_DONE : W_ACCEPT;
      W_ACCEPT: if (w_hs_c && (w_left == XW'(1))) w_state_nxt = W_DONE;
      W_DONE:   w_state_nxt = W_IDLE;
      default:  w_state_nxt = W_IDLE;
    endcase
  end

  // write datapath
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      w_idx        <= '0;
      w_left       <= '0;
      wr_tready_o  <= 1'b0;
      ctrl_wdone_o <= 1'b0;
    end else begin
      wr_tready_o  <= (w_state_nxt == W_ACCEPT) & gate_c;
      ctrl_wdone_o <= (w_state_nxt == W_DONE);
      if (w_state == W_IDLE && ctrl_wstart_i) begin
        w_idx  <= ctrl_waddr_offset_i[IW+1:2];
        w_left <= w_beats_c;
      end else if (w_state == W_ACCEPT && w_hs_c) begin
        w_idx  <= w_idx + IW'(1);
        w_left <= w_left - XW'(1);
      end
    end
  end

  // storage is deliberately not reset; a same-cycle read sees the old word
  always_ff @(posedge clk) begin
    if (w_state == W_ACCEPT && w_hs_c) mem[w_idx] <= wr_tdata_i;
  end

endmodule

// File: tb/tb_mem_stream_responder.sv
// Directed self-checking bench for mem_stream_responder (default build, no stall insertion).
module tb_mem_stream_responder;

  logic        clk;
  logic        rstn;
  logic [31:0] ctrl_raddr_offset_i;
  logic [31:0] ctrl_rxfer_size_i;
  logic        ctrl_rstart_i;
  logic        ctrl_rdone_o;
  logic [31:0] rd_tdata_o;
  logic        rd_tvalid_o;
  logic        rd_tready_i;
  logic        rd_tlast_o;
  logic [31:0] ctrl_waddr_offset_i;
  logic [31:0] ctrl_wxfer_size_i;
  logic        ctrl_wstart_i;
  logic        ctrl_wdone_o;
  logic [31:0] wr_tdata_i;
  logic        wr_tvalid_i;
  logic        wr_tready_o;

  int total;
  int bad;
  logic [31:0] exp_mem [1024];

  mem_stream_responder dut (
    .clk                 (clk),
    .rstn                (rstn),
    .ctrl_raddr_offset_i (ctrl_raddr_offset_i),
    .ctrl_rxfer_size_i   (ctrl_rxfer_size_i),
    .ctrl_rstart_i       (ctrl_rstart_i),
    .ctrl_rdone_o        (ctrl_rdone_o),
    .rd_tdata_o          (rd_tdata_o),
    .rd_tvalid_o         (rd_tvalid_o),
    .rd_tready_i         (rd_tready_i),
    .rd_tlast_o          (rd_tlast_o),
    .ctrl_waddr_offset_i (ctrl_waddr_offset_i),
    .ctrl_wxfer_size_i   (ctrl_wxfer_size_i),
    .ctrl_wstart_i       (ctrl_wstart_i),
    .ctrl_wdone_o        (ctrl_wdone_o),
    .wr_tdata_i          (wr_tdata_i),
    .wr_tvalid_i         (wr_tvalid_i),
    .wr_tready_o         (wr_tready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // streams ceil(size/4) beats of seed + k*inc with tvalid held high
  task automatic run_write(input logic [31:0] addr, input logic [31:0] size,
                           input logic [31:0] seed, input logic [31:0] inc);
    int       n;
    int       beat;
    bit       done;
    logic [9:0] idx;
    n    = int'((size + 32'd3) >> 2);
    idx  = addr[11:2];
    beat = 0;
    done = 1'b0;
    @(negedge clk);
    ctrl_waddr_offset_i = addr;
    ctrl_wxfer_size_i   = size;
    ctrl_wstart_i       = 1'b1;
    wr_tvalid_i         = 1'b0;
    @(negedge clk);
    ctrl_wstart_i = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (beat == n) begin
        check("wdone_pulse", 32'(ctrl_wdone_o), 32'd1);
        check("wready_drop", 32'(wr_tready_o), 32'd0);
        wr_tvalid_i = 1'b0;
        done = 1'b1;
      end else begin
        if (cyc == 0) check("wready_rise", 32'(wr_tready_o), 32'd1);
        wr_tvalid_i = 1'b1;
        wr_tdata_i  = seed + inc * 32'(beat);
        if (wr_tready_o) begin
          exp_mem[idx] = wr_tdata_i;
          idx  = idx + 10'd1;
          beat = beat + 1;
        end
        @(negedge clk);
      end
    end
    if (!done) check("wdone_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("wdone_single", 32'(ctrl_wdone_o), 32'd0);
  endtask

  // reads ceil(size/4) beats against the model; rnd selects random tready
  task automatic run_read(input logic [31:0] addr, input logic [31:0] size, input bit rnd);
    int         n;
    int         beat;
    int         first;
    bit         done;
    bit         prev_stall;
    logic [31:0] prev_data;
    logic [9:0] idx0;
    logic       rdy;
    n          = int'((size + 32'd3) >> 2);
    idx0       = addr[11:2];
    beat       = 0;
    first      = -1;
    done       = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    @(negedge clk);
    ctrl_raddr_offset_i = addr;
    ctrl_rxfer_size_i   = size;
    ctrl_rstart_i       = 1'b1;
    rd_tready_i         = 1'b0;
    @(negedge clk);
    ctrl_rstart_i = 1'b0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      if (beat == n) begin
        check("rdone_pulse", 32'(ctrl_rdone_o), 32'd1);
        check("rdone_tvalid", 32'(rd_tvalid_o), 32'd0);
        rd_tready_i   = 1'b0;
        ctrl_rstart_i = 1'b0;
        done = 1'b1;
      end else begin
        if (rd_tvalid_o && first < 0) first = cyc;
        if (prev_stall) begin
          check("stall_valid", 32'(rd_tvalid_o), 32'd1);
          check("stall_data", rd_tdata_o, prev_data);
        end
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rd_tvalid_o) begin
          check("rd_data", rd_tdata_o, exp_mem[idx0 + 10'(beat)]);
          check("rd_last", 32'(rd_tlast_o), 32'(beat == n - 1));
          prev_stall = !rdy;
          prev_data  = rd_tdata_o;
          if (rdy) beat = beat + 1;
        end else begin
          check("rd_last_idle", 32'(rd_tlast_o), 32'd0);
          prev_stall = 1'b0;
        end
        rd_tready_i   = rdy;
        ctrl_rstart_i = (n > 4) && (beat == 3);
        @(negedge clk);
      end
    end
    if (!done) check("rdone_timeout", 32'd0, 32'd1);
    if (!rnd && n > 0) check("rd_latency", 32'(first), 32'd2);
    @(negedge clk);
    check("rdone_single", 32'(ctrl_rdone_o), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
    rstn                = 1'b1;
    ctrl_raddr_offset_i = '0;
    ctrl_rxfer_size_i   = '0;
    ctrl_rstart_i       = 1'b0;
    rd_tready_i         = 1'b0;
    ctrl_waddr_offset_i = '0;
    ctrl_wxfer_size_i   = '0;
    ctrl_wstart_i       = 1'b0;
    wr_tdata_i          = '0;
    wr_tvalid_i         = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", 32'(rd_tvalid_o), 32'd0);
    check("rst_tlast", 32'(rd_tlast_o), 32'd0);
    check("rst_tdata", rd_tdata_o, 32'd0);
    check("rst_rdone", 32'(ctrl_rdone_o), 32'd0);
    check("rst_wready", 32'(wr_tready_o), 32'd0);
    check("rst_wdone", 32'(ctrl_wdone_o), 32'd0);
    rstn = 1'b0;
    @(negedge clk);

    // basic write then read-back of 0x11..0x44
    run_write(32'h4000_0000, 32'd16, 32'h11, 32'h11);
    run_read(32'h4000_0000, 32'd16, 1'b0);

    // 63-beat read of a partial final word with random backpressure
    run_write(32'h0000_0100, 32'd252, 32'hA500_0001, 32'h0001_0203);
    run_read(32'h0000_0100, 32'd249, 1'b1);

    // wrap from index 1023 to 0
    run_write(32'h0000_0FFC, 32'd8, 32'hDEAD_0001, 32'd1);
    check("wrap_model_hi", exp_mem[1023], 32'hDEAD_0001);
    check("wrap_model_lo", exp_mem[0], 32'hDEAD_0002);
    run_read(32'h0000_0FFC, 32'd8, 1'b0);

    // zero-length transfers
    run_read(32'h0000_0010, 32'd0, 1'b0);
    run_write(32'h0000_0010, 32'd0, 32'h0, 32'h0);

    // reset during beat 2 of 4
    @(negedge clk);
    ctrl_raddr_offset_i = 32'h4000_0000;
    ctrl_rxfer_size_i   = 32'd16;
    ctrl_rstart_i       = 1'b1;
    rd_tready_i         = 1'b1;
    @(negedge clk);
    ctrl_rstart_i = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_beat2_valid", 32'(rd_tvalid_o), 32'd1);
    check("mid_beat2_data", rd_tdata_o, exp_mem[1]);
    rstn = 1'b1;
    #1;
    check("mid_rst_tvalid", 32'(rd_tvalid_o), 32'd0);
    check("mid_rst_tlast", 32'(rd_tlast_o), 32'd0);
    check("mid_rst_rdone", 32'(ctrl_rdone_o), 32'd0);
    rd_tready_i = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_hold_rdone", 32'(ctrl_rdone_o), 32'd0);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_rdone", 32'(ctrl_rdone_o), 32'd0);
    check("post_rst_tvalid", 32'(rd_tvalid_o), 32'd0);
    run_read(32'h4000_0000, 32'd16, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
